// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: fetch FSM encoding, default widths and the
// sequential PC increment used by both the fetch unit and the branch jumper.
package fetch_unit_pkg;

    localparam int WORDSIZE_DEF         = 64;
    localparam int INSTRUCTION_SIZE_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } fetch_state_t;

    // One word forward: the next sequential instruction.
    localparam int DEFAULT_INC = 1;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: absolute redirect target, else current PC plus the
// signed jumper increment with natural two's-complement wrap.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF
) (
    input  logic [WORDSIZE-1:0] pc,
    input  logic [WORDSIZE-1:0] inc,
    input  logic                redirect_valid,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic [WORDSIZE-1:0] next_pc
);

    assign next_pc = redirect_valid ? redirect_pc : (pc + inc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the PC, runs the imem req/gnt/rvalid
// handshake and presents each fetched word until the datapath acknowledges it.
//
// state | meaning
// IDLE  | stopped, waiting for enable
// REQ   | imem_req high at pc, waiting for grant
// WAIT  | granted, waiting for response data
// HOLD  | instruction valid, waiting for instr_ack
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  WORDSIZE         = WORDSIZE_DEF,
    parameter int                  INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [WORDSIZE-1:0]         inc,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic                        imem_req,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic                        imem_gnt,
    input  logic                        imem_rvalid,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic                        instr_valid,
    input  logic                        instr_ack,
    output logic [WORDSIZE-1:0]         pc,
    output logic                        busy
);

    fetch_state_t                  state_q;
    fetch_state_t                  state_d;
    logic [WORDSIZE-1:0]           pc_q;
    logic [WORDSIZE-1:0]           next_pc;
    logic [INSTRUCTION_SIZE-1:0]   instr_q;

    fetch_unit_pc_next #(
        .WORDSIZE(WORDSIZE)
    ) u_pc_next (
        .pc             (pc_q),
        .inc            (inc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable)      state_d = REQ;
            REQ:  if (imem_gnt)    state_d = WAIT;
            WAIT: if (imem_rvalid) state_d = HOLD;
            HOLD: if (instr_ack)   state_d = enable ? REQ : IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (state_q == HOLD && instr_ack) begin
            pc_q <= next_pc;
        end
    end

    // Responses are only accepted in WAIT, so a late rvalid from an
    // aborted fetch never reaches the instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if (state_q == WAIT && imem_rvalid) begin
            instr_q <= imem_rdata;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch front end of the processor. Holds the program counter, requests instruction words from instruction memory over a request/grant/response handshake, and presents each fetched instruction to the datapath. On acknowledge, it advances the PC by the word increment computed by the branch jumper, or loads an absolute redirect target. It is the producer of the `instruction` bus and the consumer of the `inc` bus that the jumper drives.

## Interface
- `WORDSIZE`, 64, PC and increment width.
- `INSTRUCTION_SIZE`, 32, instruction width.
- `RESET_PC`, 0, PC value after reset. The PC is word-addressed: 1 means the next instruction.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run permission; sampled in IDLE and at acknowledge.
- `inc`  in  WORDSIZE  signed PC increment from the jumper (1 = sequential).
- `redirect_valid`  in  1  selects `redirect_pc` instead of `pc + inc` at acknowledge.
- `redirect_pc`  in  WORDSIZE  absolute next PC (jal/jalr target).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  WORDSIZE  fetch address; always equals `pc`.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  INSTRUCTION_SIZE  fetched instruction word.
- `instruction`  out  INSTRUCTION_SIZE  registered current instruction.
- `instr_valid`  out  1  `instruction` is valid and held stable.
- `instr_ack`  in  1  datapath has consumed the instruction; `inc` and redirect inputs are valid this cycle.
- `pc`  out  WORDSIZE  address of the current instruction.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- **IDLE:** all handshake outputs are low. If `enable` is 1, go to REQ.
- **REQ:** `imem_req` is 1 and `imem_addr` equals `pc`. On `imem_gnt`, go to WAIT. `imem_rvalid` is ignored in this state.
- **WAIT:** `imem_req` is 0. On `imem_rvalid`, capture `imem_rdata` into `instruction` and go to HOLD.
- **HOLD:** `instr_valid` is 1 and `instruction` and `pc` are stable. On `instr_ack`:
  - `pc` is loaded with `redirect_pc` if `redirect_valid` is 1, otherwise with `pc + inc` (modulo 2^WORDSIZE; two's-complement wrap, no overflow flag).
  - The next state is REQ if `enable` is 1, otherwise IDLE.
- `inc`, `redirect_valid` and `redirect_pc` are ignored unless `instr_ack` is high in HOLD.
- `instr_ack` outside HOLD has no effect.
- Dropping `enable` mid-fetch does not abort the fetch. It only takes effect at the next IDLE or acknowledge decision point.
- Reset mid-operation: the FSM returns to IDLE and `imem_req` drops immediately (asynchronously). A late `imem_rvalid` belonging to an aborted fetch is discarded, because responses are accepted only in WAIT.

## Timing
- Reset values:
  - `pc` and `imem_addr` = RESET_PC
  - `instruction` = 0
  - `instr_valid`, `imem_req`, `busy` = 0
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Minimum fetch latency: `enable` sampled high in IDLE at edge 0 → REQ during cycle 1. With `imem_gnt` in cycle 1 → WAIT in cycle 2. With `imem_rvalid` in cycle 2 → `instr_valid` in cycle 3.
- `instr_ack` in HOLD → new `pc` and `imem_req` = 1 in the following cycle. Back-to-back instructions therefore take 3 cycles each with zero-wait memory.
- Simultaneous `instr_ack` and `redirect_valid`: redirect wins.
- PC wrap: `pc` = 2^WORDSIZE−1 with `inc` = 1 gives `pc` = 0.

## Structure
- Shared processor package holds:
  - FSM state encoding (2-bit localparams).
  - Default increment constant 1 (also used by the jumper).
  - Width parameter defaults.
- Optional sub-module `pc_next`: combinational next-PC mux and adder. The FSM and all registers stay in `fetch_unit`.

## Test plan
- **Reset and first fetch:** release reset with `enable` = 1 and `imem_gnt`/`imem_rvalid` tied high with rdata 0x00000013 → `imem_addr` = 0, then `instr_valid` = 1 with `instruction` = 0x00000013 in cycle 3.
- **Sequential advance:** ack with `inc` = 1 from `pc` = 5 → next request at `imem_addr` = 6.
- **Branch taken:** ack with `inc` = −4 (all-ones…FC) at `pc` = 10 → `pc` = 6; with `inc` = 1 and `pc` = 2^64−1 → `pc` = 0.
- **Redirect priority:** ack with `redirect_valid` = 1, `redirect_pc` = 0x100, `inc` = 8 → `pc` = 0x100.
- **Memory wait states:** hold `imem_gnt` low for 3 cycles, then `imem_rvalid` 2 cycles after gnt → `imem_req` is held with a stable address, and `instr_valid` rises exactly one cycle after `imem_rvalid`.
- **Reset during WAIT followed by a stale `imem_rvalid`:** → FSM is in IDLE, `instr_valid` stays 0, `instruction` stays 0, `pc` = RESET_PC.
